row_window_feeder: RTL and testbench
====================================

Name: row_window_feeder

Overview:
- Upstream neighbour of the edge/pixel processing CHIP. Accepts one raster-order pixel stream (IMG_W x IMG_H, row-major).
- Produces the three vertically aligned pixel columns (top/mid/bottom rows of a zero-padded 3-row band) that drive CHIP's pixel_in0/1/2, one column per cycle.
- Asserts load_end on the last column of each band.
- Owns zero padding: one zero column left and right of every band, one zero row above and below the image.

Parameters:
- PIX_W, 5, pixel bit width
- IMG_W, 100, image width in pixels (band length is IMG_W+2 with padding)
- IMG_H, 100, image height in rows; must be >= 2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream pixel valid
- in_pixel  in  PIX_W  upstream pixel, raster order
- in_ready  out  1  block accepts in_pixel this cycle; transfer when in_valid & in_ready
- out_valid  out  1  pix_top/mid/bot hold a valid column
- pix_top  out  PIX_W  padded row r-1, to CHIP pixel_in0
- pix_mid  out  PIX_W  padded row r, to CHIP pixel_in1
- pix_bot  out  PIX_W  padded row r+1, to CHIP pixel_in2
- load_end  out  1  high with the last (right-pad) column of each band
- frame_done  out  1  one-cycle pulse with the final column of the frame

Behaviour:
- Storage: two IMG_W x PIX_W row buffers, prev and cur, addressed by column counter c.
  - Each accepted pixel during BAND does prev[c]<=cur[c] and cur[c]<=in_pixel in the same cycle.
- Outputs are registered. A column decided in cycle k appears on the outputs after edge k.
  - When out_valid=0, the data outputs hold their last values. load_end and frame_done are forced 0.
- Reset (asserted low, any time, including mid-frame): state=FILL, c=0, band=0, first_band=1.
  - All outputs 0; in_ready=0 during reset.
  - Buffer contents are not cleared; first_band masks them.
- FILL:
  - in_ready=1, out_valid=0.
  - Each transfer writes cur[c]; c++.
  - After IMG_W transfers: c=0, go to BAND_LPAD.
- BAND_LPAD:
  - in_ready=0. Emit (0,0,0), out_valid=1. Go to BAND_PIX.
- BAND_PIX:
  - in_ready=1.
  - On transfer, emit (first_band?0:prev[c], cur[c], in_pixel) and update buffers; c++.
  - With no transfer: out_valid=0, no state change (input stall allowed anywhere mid-row).
  - After c=IMG_W-1 transfer: go to BAND_RPAD.
- BAND_RPAD:
  - in_ready=0. Emit (0,0,0) with load_end=1. c=0, first_band=0, band++.
  - If band == IMG_H-2 before the increment: go to LAST_LPAD. Otherwise go to BAND_LPAD.
- LAST_LPAD:
  - Emit (0,0,0). Go to LAST_PIX.
- LAST_PIX:
  - in_ready=0. Emit (prev[c], cur[c], 0) every cycle with no stall; c++.
  - After c=IMG_W-1: go to LAST_RPAD.
- LAST_RPAD:
  - Emit (0,0,0) with load_end=1 and frame_done=1.
  - Go to FILL with c=0, band=0, first_band=1.
- Frame throughput with no input stall: IMG_W + IMG_H*(IMG_W+2) cycles. Exactly IMG_H bands of IMG_W+2 columns.
- Counters: c is clog2(IMG_W) bits, band is clog2(IMG_H) bits. No wrap occurs beyond the stated terminal counts.
- Simultaneous reset and transfer: reset wins, and the pixel is dropped.
- in_valid during an in_ready=0 state: ignored; upstream must hold its data.

Test Plan:
- IMG_W=4, IMG_H=3; stream rows 1,2,3,4 / 5,6,7,8 / 9,10,11,12 with in_valid held high. Required output columns:
  - Band 0: (0,0,0) (0,1,5) (0,2,6) (0,3,7) (0,4,8) (0,0,0)+load_end.
  - Band 1: (0,0,0) (1,5,9) (2,6,10) (3,7,11) (4,8,12) (0,0,0)+load_end.
  - Band 2: (0,0,0) (5,9,0) (6,10,0) (7,11,0) (8,12,0) (0,0,0)+load_end+frame_done.
  - Total 22 cycles from the first transfer.
- Same stimulus with in_valid low for 3 cycles before pixel 7 -> out_valid low exactly those 3 cycles; column (3,7,11) and all other columns unchanged.
- Two back-to-back frames, second frame all pixels 31 -> band 0 top row is 0 for every column (stale buffer masked); band 1 is (31,31,31).
- Reset pulsed low mid band 1 (after pixel 10) -> outputs 0 immediately (async), in_ready=0; after release, state FILL. A fresh frame then reproduces the scenario-1 sequence exactly.
- in_valid held high during LPAD, RPAD and LAST states -> in_ready=0 there; no pixel consumed; the next frame's pixel 1 is accepted only in FILL.
- Default params (IMG_W=100, IMG_H=100), random pixels -> 100 load_end pulses, 1 frame_done, and 10200 valid columns per frame. Every column matches a software padded-image model.

Source files
------------

// File: rtl/row_window_feeder.sv
// Converts a raster pixel stream into zero-padded 3-row columns (top/mid/bot)
// for the downstream edge processor, one column per cycle, with band/frame markers.
module row_window_feeder #(
    parameter int PIX_W = 5,
    parameter int IMG_W = 100,
    parameter int IMG_H = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] pix_top,
    output logic [PIX_W-1:0] pix_mid,
    output logic [PIX_W-1:0] pix_bot,
    output logic             load_end,
    output logic             frame_done
);

    localparam int C_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int B_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [C_W-1:0]   C_LAST = C_W'(IMG_W - 1);
    localparam logic [B_W-1:0]   B_LAST = B_W'(IMG_H - 2);
    localparam logic [C_W-1:0]   C_ONE  = C_W'(1);
    localparam logic [B_W-1:0]   B_ONE  = B_W'(1);
    localparam logic [PIX_W-1:0] ZERO   = {PIX_W{1'b0}};

    typedef enum logic [2:0] {
        ST_FILL      = 3'd0,
        ST_BAND_LPAD = 3'd1,
        ST_BAND_PIX  = 3'd2,
        ST_BAND_RPAD = 3'd3,
        ST_LAST_LPAD = 3'd4,
        ST_LAST_PIX  = 3'd5,
        ST_LAST_RPAD = 3'd6
    } state_t;

    state_t           state_r, state_s;
    logic [C_W-1:0]   c_r, c_s;
    logic [B_W-1:0]   band_r, band_s;
    logic             first_band_r, first_band_s;

    logic             in_ready_r, in_ready_s;
    logic             out_valid_r, out_valid_s;
    logic [PIX_W-1:0] pix_top_r, pix_top_s;
    logic [PIX_W-1:0] pix_mid_r, pix_mid_s;
    logic [PIX_W-1:0] pix_bot_r, pix_bot_s;
    logic             load_end_r, load_end_s;
    logic             frame_done_r, frame_done_s;

    logic [PIX_W-1:0] prev_r [IMG_W];
    logic [PIX_W-1:0] cur_r  [IMG_W];

    logic             xfer_s;
    logic             fill_wr_s;
    logic             shift_wr_s;

    // in_ready is registered so it is low during reset; a transfer always uses it.
    assign xfer_s     = in_valid & in_ready_r;

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign pix_top    = pix_top_r;
    assign pix_mid    = pix_mid_r;
    assign pix_bot    = pix_bot_r;
    assign load_end   = load_end_r;
    assign frame_done = frame_done_r;

    // Next-state, counter and next-output decode.
    always_comb begin
        state_s      = state_r;
        c_s          = c_r;
        band_s       = band_r;
        first_band_s = first_band_r;
        out_valid_s  = 1'b0;
        pix_top_s    = pix_top_r;
        pix_mid_s    = pix_mid_r;
        pix_bot_s    = pix_bot_r;
        load_end_s   = 1'b0;
        frame_done_s = 1'b0;
        fill_wr_s    = 1'b0;
        shift_wr_s   = 1'b0;

        case (state_r)
            ST_FILL: begin
                if (xfer_s) begin
                    fill_wr_s = 1'b1;
                    if (c_r == C_LAST) begin
                        c_s     = {C_W{1'b0}};
                        state_s = ST_BAND_LPAD;
                    end else begin
                        c_s = c_r + C_ONE;
                    end
                end else begin
                    c_s = c_r;
                end
            end
            ST_BAND_LPAD: begin
                out_valid_s = 1'b1;
                pix_top_s   = ZERO;
                pix_mid_s   = ZERO;
                pix_bot_s   = ZERO;
                state_s     = ST_BAND_PIX;
            end
            ST_BAND_PIX: begin
                if (xfer_s) begin
                    out_valid_s = 1'b1;
                    shift_wr_s  = 1'b1;
                    // Stale rows from a previous frame must not leak into the top row.
                    pix_top_s   = first_band_r ? ZERO : prev_r[c_r];
                    pix_mid_s   = cur_r[c_r];
                    pix_bot_s   = in_pixel;
                    if (c_r == C_LAST) begin
                        c_s     = {C_W{1'b0}};
                        state_s = ST_BAND_RPAD;
                    end else begin
                        c_s = c_r + C_ONE;
                    end
                end else begin
                    c_s = c_r;
                end
            end
            ST_BAND_RPAD: begin
                out_valid_s  = 1'b1;
                load_end_s   = 1'b1;
                pix_top_s    = ZERO;
                pix_mid_s    = ZERO;
                pix_bot_s    = ZERO;
                c_s          = {C_W{1'b0}};
                first_band_s = 1'b0;
                band_s       = band_r + B_ONE;
                if (band_r == B_LAST) begin
                    state_s = ST_LAST_LPAD;
                end else begin
                    state_s = ST_BAND_LPAD;
                end
            end
            ST_LAST_LPAD: begin
                out_valid_s = 1'b1;
                pix_top_s   = ZERO;
                pix_mid_s   = ZERO;
                pix_bot_s   = ZERO;
                state_s     = ST_LAST_PIX;
            end
            ST_LAST_PIX: begin
                out_valid_s = 1'b1;
                pix_top_s   = prev_r[c_r];
                pix_mid_s   = cur_r[c_r];
                pix_bot_s   = ZERO;
                if (c_r == C_LAST) begin
                    c_s     = {C_W{1'b0}};
                    state_s = ST_LAST_RPAD;
                end else begin
                    c_s = c_r + C_ONE;
                end
            end
            ST_LAST_RPAD: begin
                out_valid_s  = 1'b1;
                load_end_s   = 1'b1;
                frame_done_s = 1'b1;
                pix_top_s    = ZERO;
                pix_mid_s    = ZERO;
                pix_bot_s    = ZERO;
                c_s          = {C_W{1'b0}};
                band_s       = {B_W{1'b0}};
                first_band_s = 1'b1;
                state_s      = ST_FILL;
            end
            default: begin
                c_s          = {C_W{1'b0}};
                band_s       = {B_W{1'b0}};
                first_band_s = 1'b1;
                state_s      = ST_FILL;
            end
        endcase

        in_ready_s = (state_s == ST_FILL) || (state_s == ST_BAND_PIX);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_FILL;
            c_r          <= {C_W{1'b0}};
            band_r       <= {B_W{1'b0}};
            first_band_r <= 1'b1;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            pix_top_r    <= ZERO;
            pix_mid_r    <= ZERO;
            pix_bot_r    <= ZERO;
            load_end_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            c_r          <= c_s;
            band_r       <= band_s;
            first_band_r <= first_band_s;
            in_ready_r   <= in_ready_s;
            out_valid_r  <= out_valid_s;
            pix_top_r    <= pix_top_s;
            pix_mid_r    <= pix_mid_s;
            pix_bot_r    <= pix_bot_s;
            load_end_r   <= load_end_s;
            frame_done_r <= frame_done_s;
        end
    end

    // Row buffers are deliberately not reset; first_band masks their contents.
    always_ff @(posedge clk) begin
        if (fill_wr_s) begin
            cur_r[c_r] <= in_pixel;
        end else if (shift_wr_s) begin
            prev_r[c_r] <= cur_r[c_r];
            cur_r[c_r]  <= in_pixel;
        end
    end

endmodule

// File: tb/tb_row_window_feeder.sv
// Randomized and directed bench for row_window_feeder: a small 4x3 instance and a
// default 100x100 instance checked against a padded-image reference model.
module tb_row_window_feeder;

    localparam int PW = 5;
    localparam int SW = 4;
    localparam int SH = 3;
    localparam int BW = 100;
    localparam int BH = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [PW-1:0] in_pixel;
    logic          sel;

    logic          s_ready, s_valid, s_le, s_fd;
    logic [PW-1:0] s_top, s_mid, s_bot;
    logic          b_ready, b_valid, b_le, b_fd;
    logic [PW-1:0] b_top, b_mid, b_bot;

    logic          obs_ready, obs_valid, obs_le, obs_fd;
    logic [PW-1:0] obs_top, obs_mid, obs_bot;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int top;
        int mid;
        int bot;
        int le;
        int fd;
    } col_t;

    int   img[$];
    col_t exp_q[$];

    always #5 clk = ~clk;

    row_window_feeder #(.PIX_W(PW), .IMG_W(SW), .IMG_H(SH)) u_small (
        .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_pixel(in_pixel),
        .in_ready(s_ready), .out_valid(s_valid), .pix_top(s_top), .pix_mid(s_mid),
        .pix_bot(s_bot), .load_end(s_le), .frame_done(s_fd)
    );

    row_window_feeder #(.PIX_W(PW), .IMG_W(BW), .IMG_H(BH)) u_big (
        .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_pixel(in_pixel),
        .in_ready(b_ready), .out_valid(b_valid), .pix_top(b_top), .pix_mid(b_mid),
        .pix_bot(b_bot), .load_end(b_le), .frame_done(b_fd)
    );

    assign obs_ready = sel ? b_ready : s_ready;
    assign obs_valid = sel ? b_valid : s_valid;
    assign obs_le    = sel ? b_le    : s_le;
    assign obs_fd    = sel ? b_fd    : s_fd;
    assign obs_top   = sel ? b_top   : s_top;
    assign obs_mid   = sel ? b_mid   : s_mid;
    assign obs_bot   = sel ? b_bot   : s_bot;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Pixel of the zero-padded image: padded row r, padded column c.
    function automatic int pad(int r, int c, int w, int h);
        if (r < 1 || r > h || c < 1 || c > w) return 0;
        return img[(r - 1) * w + (c - 1)];
    endfunction

    task automatic build_exp(input int w, input int h);
        col_t e;
        exp_q.delete();
        for (int b = 0; b < h; b++) begin
            for (int j = 0; j < w + 2; j++) begin
                e.top = pad(b, j, w, h);
                e.mid = pad(b + 1, j, w, h);
                e.bot = pad(b + 2, j, w, h);
                e.le  = (j == w + 1) ? 1 : 0;
                e.fd  = (j == w + 1 && b == h - 1) ? 1 : 0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, obs_valid, 0);
        check({tag, "_top"}, obs_top, 0);
        check({tag, "_mid"}, obs_mid, 0);
        check({tag, "_bot"}, obs_bot, 0);
        check({tag, "_le"}, obs_le, 0);
        check({tag, "_fd"}, obs_fd, 0);
        check({tag, "_ready"}, obs_ready, 0);
    endtask

    // Streams img as one frame; stalls stall_len cycles before pixel stall_at;
    // if abort_after > 0, pulses reset once that many pixels were accepted.
    task automatic run_frame(input int w, input int h, input int stall_at,
                             input int stall_len, input int abort_after);
        int idx = 0, ncol = 0, t = 0, t_first = -1, t_done = -1;
        int nle = 0, nfd = 0, stall_left = stall_len, budget;
        bit xfer, have_last = 0;
        logic [PW-1:0] l_top, l_mid, l_bot;
        build_exp(w, h);
        budget = 4 * (w * h + h * (w + 2)) + stall_len + 50;
        while (ncol < exp_q.size() && t < budget) begin
            @(negedge clk);
            if (idx < w * h) begin
                if (idx == stall_at && stall_left > 0) begin
                    in_valid = 1'b0;
                    stall_left--;
                end else begin
                    in_valid = 1'b1;
                    in_pixel = PW'(img[idx]);
                end
            end else begin
                in_valid = 1'b1;
                in_pixel = {PW{1'b1}};
                check("ready_low_in_last_rows", obs_ready, 0);
            end
            xfer = in_valid && obs_ready;
            @(posedge clk);
            t++;
            if (xfer) begin
                idx++;
                if (t_first < 0) t_first = t;
            end
            #1;
            if (obs_valid) begin
                check("col_top", obs_top, exp_q[ncol].top);
                check("col_mid", obs_mid, exp_q[ncol].mid);
                check("col_bot", obs_bot, exp_q[ncol].bot);
                check("col_load_end", obs_le, exp_q[ncol].le);
                check("col_frame_done", obs_fd, exp_q[ncol].fd);
                if (obs_le) nle++;
                if (obs_fd) begin
                    nfd++;
                    t_done = t;
                end
                ncol++;
            end else begin
                check("idle_load_end", obs_le, 0);
                check("idle_frame_done", obs_fd, 0);
                if (have_last) begin
                    check("hold_top", obs_top, l_top);
                    check("hold_mid", obs_mid, l_mid);
                    check("hold_bot", obs_bot, l_bot);
                end
            end
            l_top = obs_top;
            l_mid = obs_mid;
            l_bot = obs_bot;
            have_last = 1;
            if (abort_after > 0 && idx == abort_after) begin
                #2;
                reset = 1'b0;
                #1;
                check_all_zero("async_reset");
                @(posedge clk);
                #1;
                check_all_zero("reset_held");
                @(negedge clk);
                in_valid = 1'b0;
                reset = 1'b1;
                @(posedge clk);
                #1;
                check("fill_after_reset_ready", obs_ready, 1);
                check("fill_after_reset_valid", obs_valid, 0);
                return;
            end
        end
        in_valid = 1'b0;
        check("frame_columns", ncol, exp_q.size());
        check("frame_load_ends", nle, h);
        check("frame_dones", nfd, 1);
        check("frame_pixels_taken", idx, w * h);
        check("frame_cycles", t_done - t_first + 1, w + h * (w + 2) + stall_len);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_pixel = {PW{1'b0}};
        sel      = 1'b0;
        #1;
        check_all_zero("reset_state");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed 4x3 frame, no stall.
        img.delete();
        for (int i = 1; i <= 12; i++) img.push_back(i);
        run_frame(SW, SH, -1, 0, 0);

        // Same frame with a three-cycle stall before pixel 7.
        run_frame(SW, SH, 6, 3, 0);

        // Random frame, then an all-31 frame back to back (stale buffers masked).
        img.delete();
        for (int i = 0; i < SW * SH; i++) img.push_back(int'($urandom_range(0, 31)));
        run_frame(SW, SH, -1, 0, 0);
        img.delete();
        for (int i = 0; i < SW * SH; i++) img.push_back(31);
        run_frame(SW, SH, int'($urandom_range(0, SW * SH - 1)), 2, 0);

        // Reset mid band 1 after pixel 10, then a fresh frame.
        img.delete();
        for (int i = 1; i <= 12; i++) img.push_back(i);
        run_frame(SW, SH, -1, 0, 10);
        run_frame(SW, SH, -1, 0, 0);

        // Default-size instance with random pixels.
        @(negedge clk);
        sel = 1'b1;
        img.delete();
        for (int i = 0; i < BW * BH; i++) img.push_back(int'($urandom_range(0, 31)));
        run_frame(BW, BH, -1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
